afifo_rd_stream: RTL and testbench

Read-side consumer for the async FIFO, sitting entirely in the read clock domain. It issues `fifo_rd_en` against the FIFO's `fifo_empty` flag and absorbs the FIFO's one-cycle read latency in a 3-entry output buffer. It presents the data as a valid/ready stream to downstream logic. It is the read-end counterpart to the write-side traffic the FIFO environment already exercises, and gives full throughput with no combinational path from `m_ready` to `fifo_rd_en`.

---
 rtl/afifo_rd_stream_pkg.sv | 25 ++
 rtl/afifo_rd_skid_buf.sv | 94 +++++++++
 rtl/afifo_rd_stream.sv | 108 ++++++++++
 tb/tb_afifo_rd_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// afifo_rd_stream_pkg
// Shared definitions for the async-FIFO read-side stream consumer:
//   AFIFO_DATA_WIDTH    default FIFO word width
//   AFIFO_RD_BUF_DEPTH  entries in the latency-absorbing output buffer
//   afifo_rd_state_e    read-consumer FSM states
//   afifo_rd_ptr_inc    buffer pointer increment with wrap 2 -> 0
// -----------------------------------------------------------------------------
package afifo_rd_stream_pkg;

    localparam int AFIFO_DATA_WIDTH   = 8;
    localparam int AFIFO_RD_BUF_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } afifo_rd_state_e;

    // Depth is not a power of two, so the pointer wrap is explicit.
    function automatic logic [1:0] afifo_rd_ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(AFIFO_RD_BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/afifo_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// afifo_rd_skid_buf
// 3-entry circular buffer that absorbs the FIFO read latency.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i/push_data_i write a word at the tail
//   pop_i              advance the head (caller guarantees valid_o)
//   head_data_o        head entry, zero while the buffer is empty
//   valid_o            registered "buffer non-empty"
//   count_o            current occupancy 0..3
//   empty_next_o       occupancy after this cycle's push/pop will be zero
// -----------------------------------------------------------------------------
module afifo_rd_skid_buf
    import afifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = AFIFO_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  valid_o,
    output logic [1:0]            count_o,
    output logic                  empty_next_o
);

    logic [DATA_WIDTH-1:0]         mem_q [AFIFO_RD_BUF_DEPTH];
    logic [1:0]                    head_q, head_d;
    logic [1:0]                    tail_q, tail_d;
    logic [1:0]                    cnt_q, cnt_d;
    logic                          valid_q;
    logic [AFIFO_RD_BUF_DEPTH-1:0] wr_sel;
    logic [DATA_WIDTH-1:0]         head_word;

    // One-hot write select per entry.
    generate
        for (genvar gi = 0; gi < AFIFO_RD_BUF_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_i && (tail_q == 2'(gi));
        end
    endgenerate

    // Storage needs no reset: the head is only exposed while valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < AFIFO_RD_BUF_DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_q[i] <= push_data_i;
            end
        end
    end

    always_comb begin
        head_d = pop_i  ? afifo_rd_ptr_inc(head_q) : head_q;
        tail_d = push_i ? afifo_rd_ptr_inc(tail_q) : tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != 2'd0);
        end
    end

    always_comb begin
        head_word = '0;
        case (head_q)
            2'd0:    head_word = mem_q[0];
            2'd1:    head_word = mem_q[1];
            2'd2:    head_word = mem_q[2];
            default: head_word = '0;
        endcase
    end

    // Gate with valid so stale entries never leak out after a reset.
    assign head_data_o  = valid_q ? head_word : '0;
    assign valid_o      = valid_q;
    assign count_o      = cnt_q;
    assign empty_next_o = (cnt_d == 2'd0);

endmodule

// File: rtl/afifo_rd_stream.sv
// -----------------------------------------------------------------------------
// afifo_rd_stream
// Read-side consumer of the async FIFO, entirely in the rclk domain. Issues
// fifo_rd_en against fifo_empty, absorbs the one-cycle FIFO read latency in a
// 3-entry buffer and presents the words as a valid/ready stream.
// Ports:
//   rclk, rrst_n     clock, synchronous active-low reset
//   enable           permit new FIFO reads
//   fifo_empty       FIFO empty flag (already in rclk domain)
//   fifo_rdata       FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       FIFO read strobe (decoded from registers + fifo_empty)
//   m_valid/m_data   stream output, m_ready downstream accept
//   rd_count         completed handshakes, wraps modulo 2^CNT_WIDTH
//   idle             FSM idle, buffer empty, nothing in flight
// -----------------------------------------------------------------------------
module afifo_rd_stream
    import afifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = AFIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  idle
);

    afifo_rd_state_e        state_q, state_d;
    logic                   inflight_q;
    logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
    logic                   idle_q, idle_d;
    logic [1:0]             buf_cnt;
    logic                   buf_empty_next;
    logic [2:0]             occupancy;
    logic                   handshake;

    afifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i        (rclk),
        .rst_ni       (rrst_n),
        .push_i       (inflight_q),
        .push_data_i  (fifo_rdata),
        .pop_i        (handshake),
        .head_data_o  (m_data),
        .valid_o      (m_valid),
        .count_o      (buf_cnt),
        .empty_next_o (buf_empty_next)
    );

    assign handshake = m_valid && m_ready;

    // Buffered words plus the word in flight must never exceed the buffer,
    // so a read is only issued when a slot is guaranteed. m_ready is not
    // consulted, keeping the downstream path out of the read strobe.
    assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight_q};
    assign fifo_rd_en = (state_q == RUN) && !fifo_empty
                        && (occupancy < 3'(AFIFO_RD_BUF_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (buf_cnt == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_count_d = rd_count_q + CNT_WIDTH'(handshake);
    // fifo_rd_en is next cycle's inflight.
    assign idle_d     = (state_d == IDLE) && buf_empty_next && !fifo_rd_en;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;  // a strobe issued during reset is dropped
            rd_count_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            rd_count_q <= rd_count_d;
            idle_q     <= idle_d;
        end
    end

    assign rd_count = rd_count_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_afifo_rd_stream.sv
module tb_afifo_rd_stream;
    import afifo_rd_stream_pkg::*;

    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en, m_valid, idle;
    logic [DW-1:0] m_data;
    logic [15:0]   rd_count;
    logic          fifo_rd_en4, m_valid4, idle4;
    logic [DW-1:0] m_data4;
    logic [3:0]    rd_count4;

    always #5 rclk = ~rclk;

    afifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count), .idle(idle)
    );

    afifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4),
        .m_data(m_data4), .m_ready(m_ready), .rd_count(rd_count4), .idle(idle4)
    );

    // Bench-side FIFO and behavioural model
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] mq[$];        // words the model holds, oldest first
    logic [DW-1:0] out_log[$];
    int            rd_log[$];
    int            hs_log[$];
    int            m_state;      // 0 idle, 1 run, 2 drain
    bit            m_inflight;
    int unsigned   m_cnt;
    int            cyc;
    bit            chk_on, verbose, w_on, w15, w16, w17;
    bit            pend_v;
    logic [DW-1:0] pend_w;
    int            n_pass, n_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic cycle(input bit en, input bit rdy, input bit rst_n, input bit stall);
        bit            e_rd, e_valid, e_idle, got_rd, hs;
        logic [DW-1:0] e_data;
        int            nxt;
        enable     = en;
        m_ready    = rdy;
        rrst_n     = rst_n;
        fifo_empty = (src_q.size() == 0) || stall;
        fifo_rdata = pend_v ? pend_w : DW'($urandom);
        #1;
        e_rd    = (m_state == 1) && !fifo_empty && (mq.size() + int'(m_inflight) < 3);
        e_valid = (mq.size() != 0);
        e_data  = e_valid ? mq[0] : '0;
        e_idle  = (m_state == 0) && (mq.size() == 0) && !m_inflight;
        if (chk_on) begin
            chk("fifo_rd_en", fifo_rd_en, e_rd);
            chk("m_valid", m_valid, e_valid);
            chk("m_data", m_data, e_data);
            chk("idle", idle, e_idle);
            chk("rd_count", rd_count, m_cnt & 32'hFFFF);
            chk("rd_count4", rd_count4, m_cnt & 32'hF);
            chk("fifo_rd_en4", fifo_rd_en4, e_rd);
            chk("m_valid4", m_valid4, e_valid);
            chk("m_data4", m_data4, e_data);
            chk("idle4", idle4, e_idle);
            chk("no_push_when_full", (dut.inflight_q && dut.buf_cnt == 2'd3), 1'b0);
        end
        if (w_on) begin
            if (hs_log.size() == 15 && !w15) begin chk("wrap15", rd_count4, 4'hF); w15 = 1; end
            if (hs_log.size() == 16 && !w16) begin chk("wrap16", rd_count4, 4'h0); w16 = 1; end
            if (hs_log.size() == 17 && !w17) begin chk("wrap17", rd_count4, 4'h1); w17 = 1; end
        end
        got_rd = (fifo_rd_en === 1'b1);
        hs     = (m_valid === 1'b1) && rdy && rst_n;
        if (got_rd) rd_log.push_back(cyc);
        if (hs) begin
            out_log.push_back(m_data);
            hs_log.push_back(cyc);
            if (verbose) $display("cycle %0d: handshake data=0x%02h rd_count=%0d", cyc, m_data, rd_count);
        end
        @(posedge rclk);
        if (!rst_n) begin
            mq.delete();
            m_inflight = 0;
            m_state    = 0;
            m_cnt      = 0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (en) nxt = 1;
                1: if (!en) nxt = 2;
                default: if (en) nxt = 1; else if (mq.size() == 0 && !m_inflight) nxt = 0;
            endcase
            if (e_valid && rdy) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_inflight) mq.push_back(fifo_rdata);
            m_inflight = e_rd;
            m_state    = nxt;
        end
        // The FIFO hands out a word for every strobe, even one issued in reset.
        pend_v = 0;
        if (got_rd && src_q.size() > 0) begin
            pend_w = src_q.pop_front();
            pend_v = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        hs_log.delete();
        out_log.delete();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(DW'(i));
    endtask

    initial begin
        int guard;
        n_pass = 0; n_chk = 0; cyc = 0;
        m_state = 0; m_inflight = 0; m_cnt = 0;
        chk_on = 0; verbose = 1; w_on = 0; pend_v = 0; pend_w = '0;

        // Reset with a non-empty FIFO and ready downstream
        for (int i = 0; i < 4; i++) src_q.push_back(8'hA0 + DW'(i));
        cycle(1, 1, 0, 0);
        chk_on = 1;
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_rd_count", rd_count, 16'h0);
        chk("rst_idle", idle, 1'b1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        chk("rel_no_enable_rd_en", fifo_rd_en, 1'b0);
        src_q.delete();
        pend_v = 0;

        // 16 preloaded words, full throughput
        clear_logs();
        load(16);
        for (int i = 0; i < 22; i++) cycle(1, 1, 1, 0);
        chk("burst_reads", rd_log.size(), 16);
        chk("burst_hs", hs_log.size(), 16);
        if (rd_log.size() == 16 && hs_log.size() == 16) begin
            chk("burst_rd_contig", rd_log[15] - rd_log[0], 15);
            chk("burst_latency", hs_log[0] - rd_log[0], 2);
            chk("burst_valid_contig", hs_log[15] - hs_log[0], 15);
            for (int i = 0; i < 16; i++) chk("burst_order", out_log[i], DW'(i));
        end
        chk("burst_rd_count", rd_count, 16'd16);
        chk("burst_idle", idle, 1'b0);

        // Backpressure: 5 words, downstream stalled
        clear_logs();
        load(5);
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
        chk("bp_reads", rd_log.size(), 3);
        chk("bp_m_valid", m_valid, 1'b1);
        chk("bp_m_data", m_data, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0);
        chk("bp_total_reads", rd_log.size(), 5);
        chk("bp_delivered", out_log.size(), 5);
        if (out_log.size() == 5)
            for (int i = 0; i < 5; i++) chk("bp_order", out_log[i], DW'(i));

        // Enable drops in the cycle of the 4th read
        clear_logs();
        load(10);
        for (int i = 0; i < 20; i++) cycle((rd_log.size() < 3) ? 1'b1 : 1'b0, 1, 1, 0);
        chk("drain_reads", rd_log.size(), 4);
        chk("drain_delivered", out_log.size(), 4);
        if (out_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("drain_order", out_log[i], DW'(i));
        chk("drain_idle", idle, 1'b1);
        chk("drain_left_in_fifo", src_q.size(), 6);
        src_q.delete();

        // Reset with buf_cnt=2 and a word in flight
        clear_logs();
        load(10);
        guard = 0;
        while (rd_log.size() < 3 && guard < 20) begin
            cycle(1, 0, 1, 0);
            guard++;
        end
        chk("mrst_setup_timeout", (guard < 20), 1'b1);
        chk("mrst_setup_cnt", dut.buf_cnt, 2'd2);
        chk("mrst_setup_inflight", dut.inflight_q, 1'b1);
        chk("mrst_count_nonzero", (rd_count != 16'd0), 1'b1);
        cycle(1, 0, 0, 0);
        chk("mrst_m_valid", m_valid, 1'b0);
        chk("mrst_rd_count", rd_count, 16'd0);
        chk("mrst_idle", idle, 1'b1);
        chk("mrst_state", dut.state_q, IDLE);
        src_q.delete();
        pend_v = 0;

        // 4-bit counter wrap over 17 handshakes
        clear_logs();
        load(17);
        w_on = 1; w15 = 0; w16 = 0; w17 = 0;
        for (int i = 0; i < 25; i++) cycle(1, 1, 1, 0);
        w_on = 0;
        chk("wrap_all_seen", {w15, w16, w17}, 3'b111);
        chk("wrap_rd_count16", rd_count, 16'd17);

        // Randomized traffic with backpressure, stalls, enable toggles, resets
        verbose = 0;
        begin
            bit en_r;
            en_r = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(99) < 45 && src_q.size() < 40) src_q.push_back(DW'($urandom));
                if ($urandom_range(99) < 5) en_r = ~en_r;
                cycle(en_r, ($urandom_range(99) < 60), !($urandom_range(999) < 4),
                      ($urandom_range(99) < 15));
            end
            for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0);
            chk("final_idle", idle, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
